// File: rtl/alu_issue_ctrl.sv
// Issue controller for the external 16-bit combinational ALU. It decodes one instruction
// per handshake from a 16x16 register file, drives the ALU, then writes back the result and the PSR.
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [7:0]        alu_opcode,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_C,
    input  logic [4:0]        alu_flags,
    output logic [4:0]        psr,
    output logic              done,
    output logic              illegal,
    input  logic              dbg_we,
    input  logic [3:0]        dbg_waddr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [3:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [7:0]        alu_op_q, alu_op_d;
    logic              alu_cin_q, alu_cin_d;
    logic [3:0]        rd_q, rd_d;
    logic              wb_en_q, wb_en_d;
    logic [DATA_W-1:0] c_hold_q, c_hold_d;
    logic [4:0]        flags_hold_q, flags_hold_d;
    logic [4:0]        psr_q, psr_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  reg_we;
    logic [DATA_W-1:0] reg_wdata;

    logic [3:0]        op_hi;
    logic [3:0]        ext;
    logic              is_reg;
    logic              is_imm;
    logic              uses_cin;
    logic              no_wb;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] operand_b;

    // Instruction decode; only 0110 zero-extends its immediate, the rest sign-extend.
    always_comb begin
        op_hi    = instr[15:12];
        ext      = instr[7:4];
        is_reg   = (op_hi == 4'b0000) || (op_hi == 4'b1000);
        is_imm   = 1'b0;
        case (op_hi)
            4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1011: is_imm = 1'b1;
            default: is_imm = 1'b0;
        endcase
        uses_cin = ((op_hi == 4'b0000) && ((ext == 4'b0111) || (ext == 4'b1000)))
                   || (op_hi == 4'b0111);
        no_wb    = (op_hi == 4'b1011)
                   || ((op_hi == 4'b0000) && ((ext == 4'b1011) || (ext == 4'b1111)));
        imm_ext  = (op_hi == 4'b0110) ? {{(DATA_W-8){1'b0}}, instr[7:0]}
                                      : {{(DATA_W-8){instr[7]}}, instr[7:0]};
        operand_b = is_reg ? regs_q[instr[3:0]] : imm_ext;
    end

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_cin_d    = alu_cin_q;
        rd_d         = rd_q;
        wb_en_d      = wb_en_q;
        c_hold_d     = c_hold_q;
        flags_hold_d = flags_hold_q;
        psr_d        = psr_q;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        reg_we       = '0;
        reg_wdata    = dbg_wdata;
        case (state_q)
            ST_IDLE: begin
                // A debug write takes priority and blocks the handshake this cycle.
                if (dbg_we) begin
                    reg_we[dbg_waddr] = 1'b1;
                end else if (instr_valid) begin
                    if (is_reg || is_imm) begin
                        alu_a_d   = regs_q[instr[11:8]];
                        alu_b_d   = operand_b;
                        alu_op_d  = {op_hi, ext};
                        alu_cin_d = uses_cin ? psr_q[3] : 1'b0;
                        rd_d      = instr[11:8];
                        wb_en_d   = ~no_wb;
                        state_d   = ST_ISSUE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                c_hold_d     = alu_C;
                flags_hold_d = alu_flags;
                done_d       = 1'b1;
                state_d      = ST_WB;
            end
            ST_WB: begin
                psr_d = flags_hold_q;
                if (wb_en_q) begin
                    reg_we[rd_q] = 1'b1;
                end
                reg_wdata = c_hold_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_cin_q    <= 1'b0;
            rd_q         <= '0;
            wb_en_q      <= 1'b0;
            c_hold_q     <= '0;
            flags_hold_q <= '0;
            psr_q        <= '0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_cin_q    <= alu_cin_d;
            rd_q         <= rd_d;
            wb_en_q      <= wb_en_d;
            c_hold_q     <= c_hold_d;
            flags_hold_q <= flags_hold_d;
            psr_q        <= psr_d;
            done_q       <= done_d;
            illegal_q    <= illegal_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regfile
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_q[gi] <= '0;
                end else if (reg_we[gi]) begin
                    regs_q[gi] <= reg_wdata;
                end
            end
        end
    endgenerate

    assign instr_ready = (state_q == ST_IDLE) && !dbg_we;
    assign alu_A       = alu_a_q;
    assign alu_B       = alu_b_q;
    assign alu_opcode  = alu_op_q;
    assign alu_cin     = alu_cin_q;
    assign psr         = psr_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign dbg_rdata   = regs_q[dbg_raddr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives alu_C/alu_flags, and an instruction-level
// register/PSR model predicts every issue and writeback.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_A, alu_B, alu_C;
    logic [7:0]  alu_opcode;
    logic        alu_cin;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done, illegal;
    logic        dbg_we;
    logic [3:0]  dbg_waddr, dbg_raddr;
    logic [15:0] dbg_wdata, dbg_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_regs [16];
    logic [4:0]  m_psr;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_opcode (alu_opcode),
        .alu_cin    (alu_cin),
        .alu_C      (alu_C),
        .alu_flags  (alu_flags),
        .psr        (psr),
        .done       (done),
        .illegal    (illegal),
        .dbg_we     (dbg_we),
        .dbg_waddr  (dbg_waddr),
        .dbg_wdata  (dbg_wdata),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    // Stand-in ALU: add family, compare family, and XOR for everything else. Returns {flags, C}.
    function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] c;
        logic [4:0]  f;
        logic [3:0]  hi, lo;
        hi = op[7:4];
        lo = op[3:0];
        f  = '0;
        if ((hi inside {4'h5, 4'h6, 4'h7}) || (hi == 4'h0 && (lo inside {4'h5, 4'h6, 4'h7}))) begin
            s    = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            c    = s[15:0];
            f[3] = s[16];
            f[2] = (a[15] == b[15]) && (c[15] != a[15]);
        end else if (hi == 4'hB || (hi == 4'h0 && (lo == 4'hB || lo == 4'hF))) begin
            c    = a - b;
            f[1] = $signed(a) < $signed(b);
            f[0] = a < b;
        end else begin
            c = a ^ b;
        end
        f[4] = (c == 16'd0);
        return {f, c};
    endfunction

    always_comb {alu_flags, alu_C} = alu_fn(alu_opcode, alu_A, alu_B, alu_cin);

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_psr = '0;
    endtask

    // Architectural effect of one instruction plus the ALU drive it should produce.
    task automatic model_step(input logic [15:0] ins, output bit legal, output logic [7:0] e_op,
                              output logic [15:0] e_a, output logic [15:0] e_b, output logic e_cin);
        logic [3:0]  oh, rd, ex;
        logic [20:0] r;
        bit          is_cmp;
        oh = ins[15:12];
        rd = ins[11:8];
        ex = ins[7:4];
        legal = oh inside {4'h0, 4'h8, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};
        e_op = {oh, ex};
        e_a  = m_regs[rd];
        if (oh == 4'h0 || oh == 4'h8) e_b = m_regs[ins[3:0]];
        else if (oh == 4'h6)          e_b = {8'h00, ins[7:0]};
        else                          e_b = {{8{ins[7]}}, ins[7:0]};
        e_cin = ((oh == 4'h0 && (ex == 4'h7 || ex == 4'h8)) || oh == 4'h7) ? m_psr[3] : 1'b0;
        if (legal) begin
            r      = alu_fn(e_op, e_a, e_b, e_cin);
            m_psr  = r[20:16];
            is_cmp = (oh == 4'hB) || (oh == 4'h0 && (ex == 4'hB || ex == 4'hF));
            if (!is_cmp) m_regs[rd] = r[15:0];
        end
    endtask

    task automatic dbg_write(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        dbg_we = 1'b1; dbg_waddr = addr; dbg_wdata = data;
        @(negedge clk);
        dbg_we = 1'b0;
        m_regs[addr] = data;
    endtask

    task automatic dbg_read(input logic [3:0] addr, output logic [15:0] data);
        dbg_raddr = addr;
        #1;
        data = dbg_rdata;
    endtask

    // Drives one handshake and samples the three negedges that follow the accept edge.
    task automatic exec_instr(input logic [15:0] ins, output logic [7:0] o_op, output logic [15:0] o_a,
                              output logic [15:0] o_b, output logic o_cin, output logic o_d1,
                              output logic o_d2, output logic o_d3, output logic o_ill1,
                              output logic o_ill2);
        int waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!instr_ready) begin
            n_fail++;
            $display("FAIL ready_timeout: instr_ready=%0b after %0d cycles, required 1", instr_ready, waited);
        end
        instr = ins; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        o_op = alu_opcode; o_a = alu_A; o_b = alu_B; o_cin = alu_cin;
        o_d1 = done; o_ill1 = illegal;
        @(negedge clk);
        o_d2 = done; o_ill2 = illegal;
        @(negedge clk);
        o_d3 = done;
    endtask

    logic [7:0]  o_op, e_op;
    logic [15:0] o_a, o_b, e_a, e_b, rv;
    logic        o_cin, e_cin, o_d1, o_d2, o_d3, o_ill1, o_ill2;
    bit          legal;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0 || psr !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%0b done=%0b illegal=%0b psr=%b, required 1 0 0 00000",
                     instr_ready, done, illegal, psr);
        end
        n_checks++;
        if (alu_A !== 16'd0 || alu_B !== 16'd0 || alu_opcode !== 8'd0 || alu_cin !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_alu: A=%h B=%h op=%h cin=%0b, required all zero", alu_A, alu_B, alu_opcode, alu_cin);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_read(i[3:0], rv);
            n_checks++;
            if (rv !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h, required 0000", i, rv);
            end
        end
    endtask

    task automatic test_addi();
        model_step(16'h5105, legal, e_op, e_a, e_b, e_cin);
        exec_instr(16'h5105, o_op, o_a, o_b, o_cin, o_d1, o_d2, o_d3, o_ill1, o_ill2);
        n_checks++;
        if (o_op !== 8'h50 || o_b !== 16'h0005 || o_a !== 16'h0000 || o_cin !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_issue: op=%h A=%h B=%h cin=%0b, required 50 0000 0005 0", o_op, o_a, o_b, o_cin);
        end
        n_checks++;
        if ({o_d1, o_d2, o_d3} !== 3'b010) begin
            n_fail++;
            $display("FAIL addi_done_timing: done seq=%b, required 010", {o_d1, o_d2, o_d3});
        end
        dbg_read(4'd1, rv);
        n_checks++;
        if (rv !== 16'h0005 || psr !== 5'b00000) begin
            n_fail++;
            $display("FAIL addi_result: R1=%h psr=%b, required 0005 00000", rv, psr);
        end
    endtask

    task automatic test_add_overflow();
        dbg_write(4'd2, 16'h7FFF);
        dbg_write(4'd3, 16'h0001);
        model_step(16'h0253, legal, e_op, e_a, e_b, e_cin);
        exec_instr(16'h0253, o_op, o_a, o_b, o_cin, o_d1, o_d2, o_d3, o_ill1, o_ill2);
        n_checks++;
        if (o_op !== 8'h05 || o_a !== 16'h7FFF || o_b !== 16'h0001) begin
            n_fail++;
            $display("FAIL add_issue: op=%h A=%h B=%h, required 05 7fff 0001", o_op, o_a, o_b);
        end
        dbg_read(4'd2, rv);
        n_checks++;
        if (rv !== 16'h8000 || psr !== 5'b00100) begin
            n_fail++;
            $display("FAIL add_overflow: R2=%h psr=%b, required 8000 00100", rv, psr);
        end
    endtask

    task automatic test_cmp();
        dbg_write(4'd4, 16'h0003);
        dbg_write(4'd5, 16'h0003);
        model_step(16'h04B5, legal, e_op, e_a, e_b, e_cin);
        exec_instr(16'h04B5, o_op, o_a, o_b, o_cin, o_d1, o_d2, o_d3, o_ill1, o_ill2);
        dbg_read(4'd4, rv);
        n_checks++;
        if (rv !== 16'h0003 || psr[4] !== 1'b1 || psr[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_no_write: R4=%h psr=%b, required 0003 with Z=1 L=0", rv, psr);
        end
    endtask

    task automatic test_carry_chain();
        dbg_write(4'd8, 16'hFFFF);
        dbg_write(4'd9, 16'h0001);
        model_step(16'h0859, legal, e_op, e_a, e_b, e_cin);
        exec_instr(16'h0859, o_op, o_a, o_b, o_cin, o_d1, o_d2, o_d3, o_ill1, o_ill2);
        n_checks++;
        if (psr !== 5'b11000) begin
            n_fail++;
            $display("FAIL add_carry_psr: psr=%b, required 11000", psr);
        end
        dbg_write(4'd6, 16'h0000);
        dbg_write(4'd7, 16'h0000);
        model_step(16'h0677, legal, e_op, e_a, e_b, e_cin);
        exec_instr(16'h0677, o_op, o_a, o_b, o_cin, o_d1, o_d2, o_d3, o_ill1, o_ill2);
        n_checks++;
        if (o_cin !== 1'b1 || o_op !== 8'h07) begin
            n_fail++;
            $display("FAIL addc_cin: cin=%0b op=%h, required 1 07", o_cin, o_op);
        end
        dbg_read(4'd6, rv);
        n_checks++;
        if (rv !== 16'h0001) begin
            n_fail++;
            $display("FAIL addc_result: R6=%h, required 0001", rv);
        end
    endtask

    task automatic test_illegal();
        logic [4:0] psr_before;
        psr_before = psr;
        exec_instr(16'h2123, o_op, o_a, o_b, o_cin, o_d1, o_d2, o_d3, o_ill1, o_ill2);
        n_checks++;
        if ({o_ill1, o_ill2} !== 2'b10 || {o_d1, o_d2, o_d3} !== 3'b000) begin
            n_fail++;
            $display("FAIL illegal_pulse: illegal seq=%b done seq=%b, required 10 000",
                     {o_ill1, o_ill2}, {o_d1, o_d2, o_d3});
        end
        n_checks++;
        if (psr !== psr_before) begin
            n_fail++;
            $display("FAIL illegal_psr: psr=%b, required %b", psr, psr_before);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_read(i[3:0], rv);
            n_checks++;
            if (rv !== m_regs[i]) begin
                n_fail++;
                $display("FAIL illegal_reg%0d: got %h, required %h", i, rv, m_regs[i]);
            end
        end
    endtask

    task automatic test_dbg_priority();
        // Debug write and a valid instruction in the same IDLE cycle: only the write happens.
        @(negedge clk);
        dbg_we = 1'b1; dbg_waddr = 4'd10; dbg_wdata = 16'h1234;
        instr = 16'h5A07; instr_valid = 1'b1;
        #1;
        n_checks++;
        if (instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL dbg_blocks_ready: ready=%0b, required 0", instr_ready);
        end
        @(negedge clk);
        dbg_we = 1'b0; instr_valid = 1'b0;
        m_regs[10] = 16'h1234;
        #1;
        n_checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL dbg_no_accept: ready=%0b done=%0b, required 1 0", instr_ready, done);
        end
        @(negedge clk);
        dbg_read(4'd10, rv);
        n_checks++;
        if (rv !== 16'h1234 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL dbg_write_win: R10=%h done=%0b, required 1234 0", rv, done);
        end
        // Debug writes while busy are dropped.
        model_step(16'h5B01, legal, e_op, e_a, e_b, e_cin);
        instr = 16'h5B01; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        dbg_we = 1'b1; dbg_waddr = 4'd12; dbg_wdata = 16'hBEEF;
        @(negedge clk);
        @(negedge clk);
        dbg_we = 1'b0;
        dbg_read(4'd12, rv);
        n_checks++;
        if (rv !== m_regs[12]) begin
            n_fail++;
            $display("FAIL dbg_busy_ignored: R12=%h, required %h", rv, m_regs[12]);
        end
        dbg_read(4'd11, rv);
        n_checks++;
        if (rv !== m_regs[11]) begin
            n_fail++;
            $display("FAIL dbg_busy_instr: R11=%h, required %h", rv, m_regs[11]);
        end
    endtask

    task automatic test_back_to_back();
        int done_idx [$];
        dbg_write(4'd1, 16'h0100);
        @(negedge clk);
        instr = 16'h5101; instr_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 8) instr_valid = 1'b0;
            if (done) done_idx.push_back(c);
            if (c == 0) begin
                n_checks++;
                if (instr_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_busy_ready: ready=%0b during ISSUE, required 0", instr_ready);
                end
            end
        end
        for (int k = 0; k < 3; k++) model_step(16'h5101, legal, e_op, e_a, e_b, e_cin);
        n_checks++;
        if (done_idx.size() != 3 || done_idx[0] != 1 || done_idx[1] != 4 || done_idx[2] != 7) begin
            n_fail++;
            $display("FAIL b2b_done_spacing: %0d pulses, first at %0d, required 3 pulses at 1/4/7",
                     done_idx.size(), (done_idx.size() > 0) ? done_idx[0] : -1);
        end
        @(negedge clk);
        dbg_read(4'd1, rv);
        n_checks++;
        if (rv !== m_regs[1]) begin
            n_fail++;
            $display("FAIL b2b_result: R1=%h, required %h", rv, m_regs[1]);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops [10] = '{4'h0, 4'h8, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h2, 4'hC, 4'hF};
        logic [15:0] ins;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) dbg_write(4'($urandom_range(0, 15)), 16'($urandom));
            ins = {ops[$urandom_range(0, 9)], 12'($urandom)};
            model_step(ins, legal, e_op, e_a, e_b, e_cin);
            exec_instr(ins, o_op, o_a, o_b, o_cin, o_d1, o_d2, o_d3, o_ill1, o_ill2);
            if (legal) begin
                n_checks++;
                if (o_op !== e_op || o_a !== e_a || o_b !== e_b || o_cin !== e_cin) begin
                    n_fail++;
                    $display("FAIL rand_issue %h: op=%h A=%h B=%h cin=%0b, required %h %h %h %0b",
                             ins, o_op, o_a, o_b, o_cin, e_op, e_a, e_b, e_cin);
                end
            end
            n_checks++;
            if ({o_d1, o_d2, o_d3, o_ill1} !== (legal ? 4'b0100 : 4'b0001)) begin
                n_fail++;
                $display("FAIL rand_pulses %h: done/illegal=%b, required %b", ins,
                         {o_d1, o_d2, o_d3, o_ill1}, (legal ? 4'b0100 : 4'b0001));
            end
            dbg_read(ins[11:8], rv);
            n_checks++;
            if (rv !== m_regs[ins[11:8]] || psr !== m_psr) begin
                n_fail++;
                $display("FAIL rand_state %h: R%0d=%h psr=%b, required %h %b", ins, ins[11:8], rv, psr,
                         m_regs[ins[11:8]], m_psr);
            end
        end
    endtask

    task automatic test_reset_abort();
        dbg_write(4'd3, 16'h0055);
        @(negedge clk);
        instr = 16'h5301; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done=%0b, required 0", done);
        end
        @(negedge clk);
        dbg_read(4'd3, rv);
        n_checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || rv !== 16'h0000 || psr !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_idle: ready=%0b done=%0b R3=%h psr=%b, required 1 0 0000 00000",
                     instr_ready, done, rv, psr);
        end
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        dbg_we = 1'b0; dbg_waddr = '0; dbg_wdata = '0; dbg_raddr = '0;
        test_reset();
        test_addi();
        test_add_overflow();
        test_cmp();
        test_carry_chain();
        test_illegal();
        test_dbg_priority();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
